// File: rtl/line_drawer_pkg.sv
// line_draw_pkg: shared types, widths and the vector-to-pixel transform for the line drawer.
package line_draw_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, DRAW} state_t;
    localparam int CW = 13;
    localparam int PW = 14;
    localparam int EW = 16;
    // neg selects the Y-up to screen-Y-down flip
    function automatic logic signed [PW-1:0] vec_to_pix(input logic signed [CW-1:0] v, input int off, input int shift, input logic neg);
        logic signed [PW-1:0] s;
        s = PW'(v) >>> shift;
        return neg ? PW'(off) - s : PW'(off) + s;
    endfunction
endpackage

// File: rtl/line_drawer_if.sv
// line_drawer_if: line-queue head, framebuffer write port and status of the line drawer.
interface line_drawer_if #(parameter int XW = 10, parameter int YW = 9);
    logic signed [12:0] q_start_x, q_end_x, q_start_y, q_end_y;
    logic [3:0]         q_intensity;
    logic               q_empty, q_read;
    logic               fb_we, fb_ready;
    logic [XW-1:0]      fb_x;
    logic [YW-1:0]      fb_y;
    logic [3:0]         fb_color;
    logic               busy;
    logic [15:0]        lines_done;
    modport master (
        output q_start_x, q_end_x, q_start_y, q_end_y, q_intensity, q_empty, fb_ready,
        input  q_read, fb_we, fb_x, fb_y, fb_color, busy, lines_done
    );
    modport slave (
        input  q_start_x, q_end_x, q_start_y, q_end_y, q_intensity, q_empty, fb_ready,
        output q_read, fb_we, fb_x, fb_y, fb_color, busy, lines_done
    );
endinterface

// File: rtl/bresenham_step.sv
// bresenham_step: combinational single Bresenham step producing the next (cx, cy, err).
module bresenham_step
    import line_draw_pkg::*;
(
    input  logic signed [PW-1:0] i_cx,
    input  logic signed [PW-1:0] i_cy,
    input  logic signed [EW-1:0] i_err,
    input  logic signed [EW-1:0] i_dx,
    input  logic signed [EW-1:0] i_dy,
    input  logic                 i_sx_neg,
    input  logic                 i_sy_neg,
    output logic signed [PW-1:0] o_cx,
    output logic signed [PW-1:0] o_cy,
    output logic signed [EW-1:0] o_err
);
    logic signed [EW-1:0] w_e2;
    logic                 w_stx, w_sty;
    assign w_e2  = i_err <<< 1;
    assign w_stx = w_e2 >= i_dy;
    assign w_sty = w_e2 <= i_dx;
    assign o_err = i_err + (w_stx ? i_dy : EW'(0)) + (w_sty ? i_dx : EW'(0));
    assign o_cx  = w_stx ? (i_sx_neg ? i_cx - PW'(1) : i_cx + PW'(1)) : i_cx;
    assign o_cy  = w_sty ? (i_sy_neg ? i_cy - PW'(1) : i_cy + PW'(1)) : i_cy;
endmodule

// File: rtl/line_drawer.sv
// line_drawer: pops line segments from the queue and rasterises them into framebuffer pixel writes.
module line_drawer
    import line_draw_pkg::*;
#(
    parameter int FB_W     = 640,
    parameter int FB_H     = 480,
    parameter int XW       = 10,
    parameter int YW       = 9,
    parameter int SHIFT    = 3,
    parameter int X_OFFSET = 320,
    parameter int Y_OFFSET = 240
) (
    input logic          clk,
    input logic          rst_b,
    line_drawer_if.slave bus
);
    localparam logic signed [PW-1:0] L_W = PW'(FB_W);
    localparam logic signed [PW-1:0] L_H = PW'(FB_H);

    state_t                r_state;
    logic signed [CW-1:0]  r_x0, r_y0, r_x1, r_y1;
    logic [3:0]            r_int;
    logic signed [PW-1:0]  r_cx, r_cy, r_px1, r_py1;
    logic signed [EW-1:0]  r_dx, r_dy, r_err;
    logic                  r_sxn, r_syn;
    logic [15:0]           r_lines;

    logic signed [PW-1:0]  w_px0, w_py0, w_px1, w_py1, w_ncx, w_ncy;
    logic signed [EW-1:0]  w_ddx, w_ddy, w_dx, w_dy, w_nerr;
    logic                  w_in_range, w_we, w_adv, w_at_end;

    assign w_px0 = vec_to_pix(r_x0, X_OFFSET, SHIFT, 1'b0);
    assign w_py0 = vec_to_pix(r_y0, Y_OFFSET, SHIFT, 1'b1);
    assign w_px1 = vec_to_pix(r_x1, X_OFFSET, SHIFT, 1'b0);
    assign w_py1 = vec_to_pix(r_y1, Y_OFFSET, SHIFT, 1'b1);
    assign w_ddx = EW'(w_px1) - EW'(w_px0);
    assign w_ddy = EW'(w_py1) - EW'(w_py0);
    assign w_dx  = w_ddx[EW-1] ? -w_ddx : w_ddx;
    assign w_dy  = w_ddy[EW-1] ? w_ddy : -w_ddy;

    assign w_in_range = !r_cx[PW-1] && r_cx < L_W && !r_cy[PW-1] && r_cy < L_H;
    assign w_we       = r_state == DRAW && w_in_range;
    // clipped pixels advance without waiting on the framebuffer
    assign w_adv      = !w_in_range || bus.fb_ready;
    assign w_at_end   = r_cx == r_px1 && r_cy == r_py1;

    bresenham_step u_step (
        .i_cx(r_cx), .i_cy(r_cy), .i_err(r_err), .i_dx(r_dx), .i_dy(r_dy),
        .i_sx_neg(r_sxn), .i_sy_neg(r_syn),
        .o_cx(w_ncx), .o_cy(w_ncy), .o_err(w_nerr)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= IDLE;
            r_x0    <= '0;
            r_y0    <= '0;
            r_x1    <= '0;
            r_y1    <= '0;
            r_int   <= '0;
            r_cx    <= '0;
            r_cy    <= '0;
            r_px1   <= '0;
            r_py1   <= '0;
            r_dx    <= '0;
            r_dy    <= '0;
            r_err   <= '0;
            r_sxn   <= 1'b0;
            r_syn   <= 1'b0;
            r_lines <= '0;
        end else begin
            case (r_state)
                IDLE: if (!bus.q_empty) begin
                    r_x0    <= bus.q_start_x;
                    r_y0    <= bus.q_start_y;
                    r_x1    <= bus.q_end_x;
                    r_y1    <= bus.q_end_y;
                    r_int   <= bus.q_intensity;
                    r_state <= SETUP;
                end
                SETUP: begin
                    r_cx    <= w_px0;
                    r_cy    <= w_py0;
                    r_px1   <= w_px1;
                    r_py1   <= w_py1;
                    r_dx    <= w_dx;
                    r_dy    <= w_dy;
                    r_err   <= w_dx + w_dy;
                    r_sxn   <= w_ddx[EW-1];
                    r_syn   <= w_ddy[EW-1];
                    r_lines <= r_int == 4'd0 ? r_lines + 16'd1 : r_lines;
                    r_state <= r_int == 4'd0 ? IDLE : DRAW;
                end
                DRAW: if (w_adv) begin
                    if (w_at_end) begin
                        r_lines <= r_lines + 16'd1;
                        r_state <= IDLE;
                    end else begin
                        r_cx  <= w_ncx;
                        r_cy  <= w_ncy;
                        r_err <= w_nerr;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // gated by rst_b so the pop strobe is silent while reset is held
    assign bus.q_read     = rst_b && r_state == IDLE && !bus.q_empty;
    assign bus.fb_we      = w_we;
    assign bus.fb_x       = w_we ? r_cx[XW-1:0] : '0;
    assign bus.fb_y       = w_we ? r_cy[YW-1:0] : '0;
    assign bus.fb_color   = w_we ? r_int : '0;
    assign bus.busy       = r_state != IDLE;
    assign bus.lines_done = r_lines;
endmodule

// File: tb/tb_line_drawer.sv
// tb_line_drawer: table-driven, hand-sequenced and randomized checks of line_drawer against a Bresenham model.
module tb_line_drawer;
    typedef struct {int x0, y0, x1, y1, inten;} seg_t;
    typedef struct {int x, y, c;} pix_t;
    typedef struct {seg_t s; int n, fx, fy, lx, ly;} vec_t;

    logic clk = 0;
    logic rst_b = 0;
    always #5 clk = ~clk;

    line_drawer_if bus ();
    line_drawer dut (.clk(clk), .rst_b(rst_b), .bus(bus.slave));

    seg_t seg_q[$];
    pix_t exp_q[$], got_q[$];
    int   n_cmp = 0, n_bad = 0, lines_exp = 0, clip_cyc = 0, held = 0;
    bit   rnd_rdy = 0, hold_v = 0, prev_qr = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int pk(input int x, input int y, input int c);
        return (x << 13) | (y << 4) | c;
    endfunction

    function automatic void drive_head();
        bus.q_empty = seg_q.size() == 0;
        if (seg_q.size() != 0) begin
            bus.q_start_x   = 13'(seg_q[0].x0);
            bus.q_start_y   = 13'(seg_q[0].y0);
            bus.q_end_x     = 13'(seg_q[0].x1);
            bus.q_end_y     = 13'(seg_q[0].y1);
            bus.q_intensity = 4'(seg_q[0].inten);
        end else begin
            bus.q_start_x   = '0;
            bus.q_start_y   = '0;
            bus.q_end_x     = '0;
            bus.q_end_y     = '0;
            bus.q_intensity = '0;
        end
    endfunction

    // Textbook Bresenham over the whole segment, keeping only on-screen pixels
    function automatic void ref_model(input seg_t s);
        int px0, py0, px1, py1, dx, dy, sx, sy, err, e2, x, y;
        px0 = 320 + (s.x0 >>> 3);
        py0 = 240 - (s.y0 >>> 3);
        px1 = 320 + (s.x1 >>> 3);
        py1 = 240 - (s.y1 >>> 3);
        lines_exp++;
        if (s.inten == 0) return;
        dx  = px1 > px0 ? px1 - px0 : px0 - px1;
        dy  = py1 > py0 ? py0 - py1 : py1 - py0;
        sx  = px1 >= px0 ? 1 : -1;
        sy  = py1 >= py0 ? 1 : -1;
        err = dx + dy;
        x   = px0;
        y   = py0;
        forever begin
            if (x >= 0 && x < 640 && y >= 0 && y < 480) exp_q.push_back('{x, y, s.inten});
            if (x == px1 && y == py1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endfunction

    function automatic void push_seg(input seg_t s);
        seg_q.push_back(s);
        ref_model(s);
        drive_head();
    endfunction

    always @(posedge clk) if (bus.q_read) begin
        #1;
        if (seg_q.size() != 0) void'(seg_q.pop_front());
        drive_head();
    end

    always @(posedge clk) begin
        #1 bus.fb_ready = rnd_rdy ? 1'($urandom_range(1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (rst_b) begin
            if (bus.q_read) begin
                chk("q_read_nonempty", int'(bus.q_empty), 0);
                chk("q_read_single", int'(prev_qr), 0);
            end
            if (hold_v) begin
                chk("hold_we", int'(bus.fb_we), 1);
                chk("hold_pix", pk(int'(bus.fb_x), int'(bus.fb_y), int'(bus.fb_color)), held);
            end
            if (bus.fb_we && bus.fb_ready) got_q.push_back('{int'(bus.fb_x), int'(bus.fb_y), int'(bus.fb_color)});
            if (bus.busy && !bus.fb_we) clip_cyc++;
            hold_v  = bus.fb_we && !bus.fb_ready;
            held    = pk(int'(bus.fb_x), int'(bus.fb_y), int'(bus.fb_color));
            prev_qr = bus.q_read;
        end else begin
            hold_v  = 0;
            prev_qr = 0;
        end
    end

    task automatic wait_done(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (seg_q.size() == 0 && !bus.busy && !bus.q_read) break;
        end
        if (i == budget) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_done: timeout after %0d cycles", budget);
        end
    endtask

    task automatic check_seq(input string tag);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk({tag, "_pix"}, pk(got_q[i].x, got_q[i].y, got_q[i].c), pk(exp_q[i].x, exp_q[i].y, exp_q[i].c));
        chk({tag, "_lines"}, int'(bus.lines_done), lines_exp);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic chk_pix(input string name, input int x, input int y, input int c);
        chk({name, "_we"}, int'(bus.fb_we), 1);
        chk({name, "_xyc"}, pk(int'(bus.fb_x), int'(bus.fb_y), int'(bus.fb_color)), pk(x, y, c));
    endtask

    vec_t vecs[6];
    seg_t s1, s2;

    initial begin
        bus.fb_ready = 1'b1;
        drive_head();
        #1;
        chk("rst_we", int'(bus.fb_we), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_lines", int'(bus.lines_done), 0);
        chk("rst_q_read", int'(bus.q_read), 0);
        chk("rst_xyc", pk(int'(bus.fb_x), int'(bus.fb_y), int'(bus.fb_color)), 0);
        @(negedge clk);
        @(negedge clk);
        rst_b = 1;

        vecs[0] = '{'{0, 0, 16, 8, 9}, 3, 320, 240, 322, 239};
        vecs[1] = '{'{8, 8, 8, 8, 5}, 1, 321, 239, 321, 239};
        vecs[2] = '{'{0, 0, 800, 0, 0}, 0, 0, 0, 0, 0};
        vecs[3] = '{'{2480, 0, 2640, 0, 3}, 10, 630, 240, 639, 240};
        vecs[4] = '{'{-8, -8, -24, -8, 1}, 3, 319, 241, 317, 241};
        vecs[5] = '{'{0, 0, 0, -40, 15}, 6, 320, 240, 320, 245};
        foreach (vecs[i]) begin
            @(negedge clk);
            push_seg(vecs[i].s);
            wait_done(2000);
            chk($sformatf("vec%0d_n", i), got_q.size(), vecs[i].n);
            if (got_q.size() > 0 && vecs[i].n > 0) begin
                chk($sformatf("vec%0d_first", i), pk(got_q[0].x, got_q[0].y, got_q[0].c), pk(vecs[i].fx, vecs[i].fy, vecs[i].s.inten));
                chk($sformatf("vec%0d_last", i), pk(got_q[$].x, got_q[$].y, got_q[$].c), pk(vecs[i].lx, vecs[i].ly, vecs[i].s.inten));
            end
            check_seq($sformatf("vec%0d", i));
        end

        // Cycle-exact timing of a 3-pixel segment followed back-to-back by a zero-length one
        @(negedge clk);
        push_seg('{0, 0, 16, 8, 9});
        push_seg('{8, 8, 8, 8, 5});
        #1 chk("lat_q_read", int'(bus.q_read), 1);
        @(negedge clk);
        chk("lat_setup_we", int'(bus.fb_we), 0);
        chk("lat_setup_busy", int'(bus.busy), 1);
        chk("lat_setup_q_read", int'(bus.q_read), 0);
        @(negedge clk) chk_pix("lat_p0", 320, 240, 9);
        @(negedge clk) chk_pix("lat_p1", 321, 239, 9);
        @(negedge clk) chk_pix("lat_p2", 322, 239, 9);
        @(negedge clk);
        chk("b2b_busy", int'(bus.busy), 0);
        chk("b2b_q_read", int'(bus.q_read), 1);
        @(negedge clk) chk("b2b_setup_we", int'(bus.fb_we), 0);
        @(negedge clk) chk_pix("zero_len", 321, 239, 5);
        @(negedge clk) chk("zero_len_done", int'(bus.busy), 0);
        check_seq("b2b");

        // Blank segment returns to IDLE two cycles after its pop
        push_seg('{0, 0, 800, 0, 0});
        #1 chk("blank_q_read", int'(bus.q_read), 1);
        @(negedge clk) chk("blank_setup_busy", int'(bus.busy), 1);
        @(negedge clk);
        chk("blank_idle_busy", int'(bus.busy), 0);
        chk("blank_idle_we", int'(bus.fb_we), 0);
        check_seq("blank");

        // Clip accounting: setup cycle plus 11 clipped pixels with fb_we low
        @(negedge clk);
        clip_cyc = 0;
        push_seg('{2480, 0, 2640, 0, 6});
        wait_done(2000);
        chk("clip_cycles", clip_cyc, 12);
        check_seq("clip");

        rnd_rdy = 1;
        @(negedge clk);
        push_seg('{0, 0, 160, -160, 7});
        wait_done(4000);
        check_seq("diag");

        for (int k = 0; k < 10; k++)
            push_seg('{int'($urandom_range(3200)) - 1600, int'($urandom_range(3200)) - 1600,
                       int'($urandom_range(3200)) - 1600, int'($urandom_range(3200)) - 1600,
                       int'($urandom_range(15))});
        wait_done(40000);
        check_seq("rand");

        // Async reset in the middle of a long segment; the queued one must still be drawn
        rnd_rdy = 0;
        @(negedge clk);
        s1 = '{0, 0, 800, 0, 2};
        s2 = '{0, 0, 16, 8, 9};
        push_seg(s1);
        push_seg(s2);
        repeat (10) @(negedge clk);
        chk("pre_rst_we", int'(bus.fb_we), 1);
        #2 rst_b = 0;
        #1;
        chk("arst_we", int'(bus.fb_we), 0);
        chk("arst_busy", int'(bus.busy), 0);
        chk("arst_lines", int'(bus.lines_done), 0);
        chk("arst_q_read", int'(bus.q_read), 0);
        chk("arst_xyc", pk(int'(bus.fb_x), int'(bus.fb_y), int'(bus.fb_color)), 0);
        got_q.delete();
        exp_q.delete();
        lines_exp = 0;
        ref_model(s2);
        @(negedge clk);
        @(negedge clk);
        #2 rst_b = 1;
        wait_done(2000);
        check_seq("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/line_drawer.md
Name: line_drawer

Overview:
- Consumer end of the line-segment queue: pops one segment at a time from the vector generator's line register queue and rasterises it with Bresenham.
- Emits one framebuffer pixel write per cycle over a valid/ready handshake.
- Sits between the line queue and the framebuffer write port; it turns vector-space endpoints into screen pixels.

Parameters:
- FB_W, 640, framebuffer width in pixels
- FB_H, 480, framebuffer height in pixels
- XW, 10, fb_x width
- YW, 9, fb_y width
- SHIFT, 3, arithmetic right shift from vector coordinates to pixels
- X_OFFSET, 320, pixel column of vector origin
- Y_OFFSET, 240, pixel row of vector origin

Ports:
- clk  in  1  system clock
- rst_b  in  1  reset; asynchronous, active-low
- q_start_x, q_end_x, q_start_y, q_end_y  in  13 each  head segment endpoints, signed two's complement, valid while !q_empty
- q_intensity  in  4  head segment intensity
- q_empty  in  1  queue empty
- q_read  out  1  one-cycle pop strobe to the queue
- fb_we  out  1  pixel valid
- fb_ready  in  1  framebuffer accepts pixel
- fb_x  out  XW  pixel column
- fb_y  out  YW  pixel row
- fb_color  out  4  pixel intensity
- busy  out  1  segment in progress
- lines_done  out  16  count of segments consumed, wraps

Behaviour:
- Reset (rst_b low, async): state IDLE; all outputs 0; internal registers 0.
- Coordinate transform, done in SETUP:
  - px = X_OFFSET + (x >>> SHIFT)
  - py = Y_OFFSET - (y >>> SHIFT), so vector Y-up maps to screen Y-down
  - Signed 14-bit arithmetic.
- IDLE:
  - If !q_empty: latch all q_* inputs, assert q_read for exactly this cycle, go to SETUP.
  - q_read is never asserted when q_empty, and never for two consecutive cycles.
- SETUP (1 cycle):
  - Compute px0, py0, px1, py1.
  - dx = |px1-px0|, dy = -|py1-py0|, sx/sy = +1 or -1, err = dx+dy. err is signed 16 bits.
  - If latched intensity == 0: increment lines_done and go to IDLE with no pixels emitted (blank segment).
  - Otherwise go to DRAW.
- DRAW:
  - Current pixel (cx, cy) is in range when 0 <= cx < FB_W and 0 <= cy < FB_H.
  - In range: drive fb_we=1 with fb_x/fb_y/fb_color; hold them stable until fb_ready is sampled high.
  - Out of range: fb_we=0; the step proceeds without waiting (clipping costs 1 cycle per pixel).
  - On acceptance or clip, check the endpoint first. If (cx,cy) == (px1,py1): increment lines_done and go to IDLE.
  - Otherwise step:
    - e2 = 2*err
    - if e2 >= dy: err += dy, cx += sx
    - if e2 <= dx: err += dx, cy += sy
- Latency: the first pixel's fb_we asserts 2 cycles after the q_read cycle. An accepted pixel costs 1 cycle when fb_ready is tied high.
- The IDLE return cycle is a dead cycle. With back-to-back segments, the next q_read comes 1 cycle after the last pixel is accepted.
- Zero-length segment (start == end): exactly one pixel.
- busy = 1 in SETUP and DRAW.
- fb_ready high while fb_we low is ignored.
- Async reset mid-DRAW abandons the segment; that segment was already popped and is lost.

Decomposition:
- Package line_draw_pkg:
  - state enum {IDLE, SETUP, DRAW}
  - coordinate width constant 13
  - pixel-math width 14
  - err width 16
  - a function for the vector-to-pixel transform
- One sub-module, bresenham_step: combinational next (cx, cy, err) from (cx, cy, err, dx, dy, sx, sy). Used so the step can be unit-tested alone.

Test Plan:
- Segment (0,0)->(16,8), intensity 9, fb_ready=1 -> q_read one pulse; pixels in order (320,240), (321,239), (322,239) with fb_color=9; lines_done=1; busy falls after the 3rd pixel.
- Zero-length (8,8)->(8,8), intensity 5 -> exactly one write, (321,239).
- Intensity 0 segment (0,0)->(800,0) -> no fb_we; lines_done increments; back in IDLE 2 cycles after q_read.
- Segment (2480,0)->(2640,0) (px 630..650), fb_ready=1 -> writes for px 630..639 only; 11 clipped cycles with fb_we=0; lines_done=1.
- fb_ready toggled randomly on a 20-pixel diagonal -> fb_x/fb_y/fb_color stable while fb_we && !fb_ready; no pixel duplicated or dropped; ordered sequence matches a reference Bresenham model.
- Two queued segments, then rst_b pulsed low mid-DRAW of the first -> outputs 0 immediately (async); after release, the second segment is drawn and lines_done=1; q_read never asserted while q_empty.
